// File: rtl/int_div_32.sv
// rtl/int_div_32.sv - iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
// Registers update on the falling clock edge; one quotient bit per cycle.
module int_div_32 #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_div_i,
  input  logic [OPERAND_SIZE-1:0] X,
  input  logic [OPERAND_SIZE-1:0] Y,
  output logic                    busy,
  output logic                    result_rdy,
  output logic [OPERAND_SIZE-1:0] Quotient,
  output logic [OPERAND_SIZE-1:0] Remainder
);

  localparam int W  = OPERAND_SIZE;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    rem_q;
  logic [W-1:0]    dvd_q;
  logic [W-1:0]    dvs_q;
  logic            negq_q;
  logic            negr_q;

  logic [W-1:0]    x_abs;
  logic [W-1:0]    y_abs;
  logic            y_zero;
  logic            sgn_ovf;
  logic [W:0]      diff;
  logic [W-1:0]    rem_d;
  logic [W-1:0]    dvd_d;

  assign x_abs   = (signed_div_i && X[W-1]) ? -X : X;
  assign y_abs   = (signed_div_i && Y[W-1]) ? -Y : Y;
  assign y_zero  = ~|Y;
  assign sgn_ovf = signed_div_i && (X == {1'b1, {(W-1){1'b0}}}) && (&Y);

  // dvd_q shifts the dividend out of its MSB and collects quotient bits in its LSB.
  assign diff  = {rem_q, dvd_q[W-1]} - {1'b0, dvs_q};
  assign rem_d = diff[W] ? {rem_q[W-2:0], dvd_q[W-1]} : diff[W-1:0];
  assign dvd_d = {dvd_q[W-2:0], ~diff[W]};

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
      Quotient   <= '0;
      Remainder  <= '0;
    end else begin
      result_rdy <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_q <= '0;
            // Special cases park their final values in dvd_q/rem_q and skip the iterations.
            if (y_zero) begin
              dvd_q   <= '1;
              rem_q   <= X;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= S_FIX;
            end else if (sgn_ovf) begin
              dvd_q   <= {1'b1, {(W-1){1'b0}}};
              rem_q   <= '0;
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              state_q <= S_FIX;
            end else begin
              dvd_q   <= x_abs;
              dvs_q   <= y_abs;
              rem_q   <= '0;
              negq_q  <= signed_div_i && (X[W-1] ^ Y[W-1]);
              negr_q  <= signed_div_i && X[W-1];
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          Quotient   <= negq_q ? -dvd_q : dvd_q;
          Remainder  <= negr_q ? -rem_q : rem_q;
          result_rdy <= 1'b1;
          busy       <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_32.sv
// tb/tb_int_div_32.sv - directed self-checking bench for int_div_32
// DUT updates on negedge; outputs are sampled on posedge.
module tb_int_div_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_div_i;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        result_rdy;
  logic [31:0] Quotient;
  logic [31:0] Remainder;

  int n_checks = 0;
  int n_pass   = 0;

  int_div_32 #(.OPERAND_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_div_i(signed_div_i),
    .X(X), .Y(Y), .busy(busy), .result_rdy(result_rdy),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Accept edge is edge 0; sample e reflects the state after edge e.
  task automatic run_op(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                        input int window, output int lat, output int pulses, output int busy_cnt);
    signed_div_i = sgn; X = x; Y = y; start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0; X = 32'hA5A5_5A5A; Y = 32'h1234_5678; signed_div_i = ~sgn;
    lat = -1; pulses = 0; busy_cnt = 0;
    for (int e = 0; e <= window; e++) begin
      @(posedge clk);
      if (result_rdy) begin
        pulses++;
        if (lat < 0) lat = e;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_div_i = 1'b0; X = '0; Y = '0;
    #12;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (result_rdy !== 1'b0) $display("FAIL reset_rdy got %0b want 0", result_rdy); else n_pass++;
    n_checks++; if (Quotient !== 32'h0) $display("FAIL reset_q got %h want 0", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'h0) $display("FAIL reset_r got %h want 0", Remainder); else n_pass++;
    @(posedge clk); rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_unsigned();
    int lat, p, b;
    run_op(1'b0, 32'd100, 32'd7, 40, lat, p, b);
    n_checks++; if (lat !== 33) $display("FAIL u100_7_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (p !== 1) $display("FAIL u100_7_pulses got %0d want 1", p); else n_pass++;
    n_checks++; if (b !== 33) $display("FAIL u100_7_busy_cycles got %0d want 33", b); else n_pass++;
    n_checks++; if (Quotient !== 32'd14) $display("FAIL u100_7_q got %h want e", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd2) $display("FAIL u100_7_r got %h want 2", Remainder); else n_pass++;
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 40, lat, p, b);
    n_checks++; if (Quotient !== 32'hFFFF_FFFF) $display("FAIL uffff_1_q got %h want ffffffff", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'h0) $display("FAIL uffff_1_r got %h want 0", Remainder); else n_pass++;
  endtask

  task automatic test_signed();
    int lat, p, b;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 40, lat, p, b);
    n_checks++; if (lat !== 33) $display("FAIL sm7_2_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (Quotient !== 32'hFFFF_FFFD) $display("FAIL sm7_2_q got %h want fffffffd", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'hFFFF_FFFF) $display("FAIL sm7_2_r got %h want ffffffff", Remainder); else n_pass++;
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 40, lat, p, b);
    n_checks++; if (Quotient !== 32'hFFFF_FFFD) $display("FAIL s7_m2_q got %h want fffffffd", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd1) $display("FAIL s7_m2_r got %h want 1", Remainder); else n_pass++;
    run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 40, lat, p, b);
    n_checks++; if (Quotient !== 32'd3) $display("FAIL sm7_m2_q got %h want 3", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'hFFFF_FFFF) $display("FAIL sm7_m2_r got %h want ffffffff", Remainder); else n_pass++;
  endtask

  task automatic test_div_zero();
    int lat, p, b;
    run_op(1'b0, 32'd5, 32'd0, 5, lat, p, b);
    n_checks++; if (lat !== 1) $display("FAIL dz_u_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (p !== 1) $display("FAIL dz_u_pulses got %0d want 1", p); else n_pass++;
    n_checks++; if (Quotient !== 32'hFFFF_FFFF) $display("FAIL dz_u_q got %h want ffffffff", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd5) $display("FAIL dz_u_r got %h want 5", Remainder); else n_pass++;
    run_op(1'b1, 32'd5, 32'd0, 5, lat, p, b);
    n_checks++; if (lat !== 1) $display("FAIL dz_s_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (Quotient !== 32'hFFFF_FFFF) $display("FAIL dz_s_q got %h want ffffffff", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd5) $display("FAIL dz_s_r got %h want 5", Remainder); else n_pass++;
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 5, lat, p, b);
    n_checks++; if (Quotient !== 32'hFFFF_FFFF) $display("FAIL dz_sm5_q got %h want ffffffff", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'hFFFF_FFFB) $display("FAIL dz_sm5_r got %h want fffffffb", Remainder); else n_pass++;
  endtask

  task automatic test_overflow();
    int lat, p, b;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, lat, p, b);
    n_checks++; if (lat !== 1) $display("FAIL ovf_s_lat got %0d want 1", lat); else n_pass++;
    n_checks++; if (b !== 1) $display("FAIL ovf_s_busy_cycles got %0d want 1", b); else n_pass++;
    n_checks++; if (Quotient !== 32'h8000_0000) $display("FAIL ovf_s_q got %h want 80000000", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'h0) $display("FAIL ovf_s_r got %h want 0", Remainder); else n_pass++;
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 40, lat, p, b);
    n_checks++; if (lat !== 33) $display("FAIL ovf_u_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (Quotient !== 32'h0) $display("FAIL ovf_u_q got %h want 0", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'h8000_0000) $display("FAIL ovf_u_r got %h want 80000000", Remainder); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat = -1;
    int p = 0;
    signed_div_i = 1'b0; X = 32'd100; Y = 32'd7; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      if (result_rdy) begin
        p++;
        if (lat < 0) lat = e;
      end
      if (e == 9) begin
        start = 1'b1; X = 32'd50; Y = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    n_checks++; if (lat !== 33) $display("FAIL ign_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (p !== 1) $display("FAIL ign_pulses got %0d want 1", p); else n_pass++;
    n_checks++; if (Quotient !== 32'd14) $display("FAIL ign_q got %h want e", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd2) $display("FAIL ign_r got %h want 2", Remainder); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, p, b;
    run_op(1'b0, 32'd1000, 32'd7, 33, lat, p, b);
    n_checks++; if (result_rdy !== 1'b1) $display("FAIL b2b_first_rdy got %0b want 1", result_rdy); else n_pass++;
    n_checks++; if (Quotient !== 32'd142) $display("FAIL b2b_first_q got %h want 8e", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd6) $display("FAIL b2b_first_r got %h want 6", Remainder); else n_pass++;
    run_op(1'b0, 32'd1000, 32'd10, 40, lat, p, b);
    n_checks++; if (lat !== 33) $display("FAIL b2b_second_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (Quotient !== 32'd100) $display("FAIL b2b_second_q got %h want 64", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd0) $display("FAIL b2b_second_r got %h want 0", Remainder); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int lat, p, b;
    signed_div_i = 1'b0; X = 32'd1000; Y = 32'd7; start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    for (int e = 0; e <= 14; e++) @(posedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy got %0b want 1", busy); else n_pass++;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %0b want 0", busy); else n_pass++;
    n_checks++; if (result_rdy !== 1'b0) $display("FAIL rst_mid_rdy got %0b want 0", result_rdy); else n_pass++;
    n_checks++; if (Quotient !== 32'h0) $display("FAIL rst_mid_q got %h want 0", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'h0) $display("FAIL rst_mid_r got %h want 0", Remainder); else n_pass++;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    p = 0; b = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      if (result_rdy) p++;
      if (busy) b++;
    end
    n_checks++; if (p !== 0) $display("FAIL rst_no_pulse got %0d want 0", p); else n_pass++;
    n_checks++; if (b !== 0) $display("FAIL rst_no_busy got %0d want 0", b); else n_pass++;
    run_op(1'b0, 32'd20, 32'd3, 40, lat, p, b);
    n_checks++; if (lat !== 33) $display("FAIL rst_after_lat got %0d want 33", lat); else n_pass++;
    n_checks++; if (Quotient !== 32'd6) $display("FAIL rst_after_q got %h want 6", Quotient); else n_pass++;
    n_checks++; if (Remainder !== 32'd2) $display("FAIL rst_after_r got %h want 2", Remainder); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
